// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier.
//   state_e  : top-level FSM states (IDLE, CALC)
//   digit_e  : radix-4 Booth digits (ZERO, POS1, POS2, NEG1, NEG2)
//   recode() : maps a {Q[1],Q[0],q_-1} triplet to a Booth digit
package booth_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_e;

  // Standard radix-4 Booth recoding of an overlapping bit triplet.
  function automatic digit_e recode(input logic [2:0] triplet);
    digit_e dig;
    case (triplet)
      3'b000:  dig = ZERO;
      3'b001:  dig = POS1;
      3'b010:  dig = POS1;
      3'b011:  dig = POS2;
      3'b100:  dig = NEG2;
      3'b101:  dig = NEG1;
      3'b110:  dig = NEG1;
      3'b111:  dig = ZERO;
      default: dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: combinational partial-product generator.
//   triplet_i : {Q[1], Q[0], q_-1} from the multiplier shift register
//   m_ext_i   : multiplicand already extended to WIDTH+2 bits
//   pp_o      : digit * M, sign-extended to the accumulator width WIDTH+4
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       triplet_i,
  input  logic [WIDTH+1:0] m_ext_i,
  output logic [WIDTH+3:0] pp_o
);

  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 4;

  digit_e        digit_s;
  logic [AW-1:0] m_wide_s;
  logic [AW-1:0] m_dbl_s;

  assign digit_s  = recode(triplet_i);
  // m_ext_i is already sign- or zero-extended, so replicating its MSB is
  // correct in both operand modes.
  assign m_wide_s = {{2{m_ext_i[XW-1]}}, m_ext_i};
  assign m_dbl_s  = {m_wide_s[AW-2:0], 1'b0};

  // Select the signed multiple of M for the current Booth digit.
  always_comb begin
    pp_o = '0;
    case (digit_s)
      ZERO:    pp_o = '0;
      POS1:    pp_o = m_wide_s;
      POS2:    pp_o = m_dbl_s;
      NEG1:    pp_o = ~m_wide_s + AW'(1);
      NEG2:    pp_o = ~m_dbl_s + AW'(1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_r4.sv
// booth_mul_r4: sequential radix-4 Booth multiplier, WIDTH/2+1 iterations.
//   clk, resetN          : rising-edge clock, async active-low reset
//   start, signed_mode   : request and operand mode, sampled only in IDLE
//   clear                : synchronous abort of an operation in progress
//   multiplicand, multiplier : operands M and Q (WIDTH bits)
//   busy                 : high while the FSM is in CALC
//   done                 : one-cycle pulse when product is updated
//   product              : registered 2*WIDTH result, held between completions
// WIDTH must be even and at least 4.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic               signed_mode,
  input  logic               clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int AW   = WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      a_q, a_d;
  logic [XW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [XW-1:0]      m_q, m_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [AW-1:0]      pp_s;
  logic [AW-1:0]      a_sum_s;
  logic [AW-1:0]      a_sh_s;
  logic [XW-1:0]      q_sh_s;
  logic [XW-1:0]      m_load_s;
  logic [XW-1:0]      q_load_s;

  booth_r4_recoder #(
    .WIDTH (WIDTH)
  ) u_recoder (
    .triplet_i ({q_q[1:0], qm1_q}),
    .m_ext_i   (m_q),
    .pp_o      (pp_s)
  );

  assign m_load_s = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
  assign q_load_s = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                : {2'b00, multiplier};

  // Accumulate, then arithmetic-shift {A,Q,q_-1} right by two bits.
  assign a_sum_s = a_q + pp_s;
  assign a_sh_s  = {{2{a_sum_s[AW-1]}}, a_sum_s[AW-1:2]};
  assign q_sh_s  = {a_sum_s[1:0], q_q[XW-1:2]};

  // Next-state logic: load, iterate, complete or abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // clear outranks start; in IDLE it otherwise does nothing.
        if (start && !clear) begin
          m_d     = m_load_s;
          q_d     = q_load_s;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(ITER);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (clear) begin
          state_d = IDLE;
        end else begin
          a_d   = a_sh_s;
          q_d   = q_sh_s;
          qm1_d = q_q[1];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Q has been fully replaced by low product bits after the final
            // shift; the rest of the 2*WIDTH result sits at the bottom of A.
            product_d = {a_sh_s[WIDTH-3:0], q_sh_s};
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = CALC;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mul_r4.sv
// Directed testbench for booth_mul_r4 (WIDTH=8, ITER=5) with hand-computed
// expected products.
module tb_booth_mul_r4;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        signed_mode;
  logic        clear;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_vec;
  int n_err;

  booth_mul_r4 #(.WIDTH(8)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .signed_mode  (signed_mode),
    .clear        (clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sm, input logic [7:0] m, input logic [7:0] q);
    start        = s;
    signed_mode  = sm;
    multiplicand = m;
    multiplier   = q;
  endtask

  // Full operation: checks latency, busy length, done width and product.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] m,
                        input logic [7:0] q, input logic [15:0] exp);
    int busy_cycles;
    int done_at;
    int done_cnt;
    logic [15:0] got;
    busy_cycles = 0;
    done_at     = 0;
    done_cnt    = 0;
    got         = 16'h0000;
    drive(1'b1, sm, m, q);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      if (busy) busy_cycles++;
      tick();
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          got     = product;
        end
      end
    end
    chk({tag, "_lat"},  done_at, 5);
    chk({tag, "_busy"}, busy_cycles, 5);
    chk({tag, "_dpw"},  done_cnt, 1);
    chk({tag, "_prod"}, {16'h0000, got}, {16'h0000, exp});
  endtask

  typedef struct {
    logic        sm;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    n_vec = 0;
    n_err = 0;
    resetN = 1'b0;
    clear  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};   // -128 * -128
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};   // 255 * 255
    vecs[2] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};   // -3 * 5
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 16'hC080};   // 127 * -128
    vecs[4] = '{1'b0, 8'h80, 8'hFF, 16'h7F80};   // 128 * 255
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};   // -1 * -1
    vecs[6] = '{1'b0, 8'h00, 8'hAB, 16'h0000};   // 0 * 171

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", product, 16'h0000);
    resetN = 1'b1;
    #1;

    foreach (vecs[i]) run_op($sformatf("v%0d", i), vecs[i].sm, vecs[i].m, vecs[i].q, vecs[i].exp);

    // Back-to-back: restart in the done cycle, no idle gap.
    drive(1'b1, 1'b1, 8'hFD, 8'h05);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("b2b_done1", done, 1'b1);
    chk("b2b_prod1", product, 16'hFFF1);
    drive(1'b1, 1'b1, 8'hFD, 8'h05);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("b2b_busy2", busy, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_early", done, 1'b0);
    tick();
    chk("b2b_done2", done, 1'b1);
    chk("b2b_prod2", product, 16'hFFF1);
    tick();

    // start pulsed while busy must be ignored.
    drive(1'b1, 1'b0, 8'h12, 8'h34);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b1, 1'b0, 8'h01, 8'h01);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    chk("ign_done", done, 1'b1);
    chk("ign_prod", product, 16'h03A8);
    tick();
    chk("ign_busy", busy, 1'b0);
    chk("ign_done0", done, 1'b0);

    // clear mid-operation aborts: no done, product retained.
    drive(1'b1, 1'b1, 8'h07, 8'h06);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", busy, 1'b0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) seen++;
        tick();
      end
      chk("clr_nodone", seen, 0);
    end
    chk("clr_prod", product, 16'h03A8);

    // clear outranks start in IDLE.
    clear = 1'b1;
    drive(1'b1, 1'b0, 8'h02, 8'h02);
    tick();
    clear = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    chk("clr_pri", busy, 1'b0);

    // Asynchronous reset in the middle of CALC.
    drive(1'b1, 1'b0, 8'h0A, 8'h0B);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    #2;
    resetN = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_prod", product, 16'h0000);
    #1;
    resetN = 1'b1;
    #1;
    run_op("post_rst", 1'b0, 8'h0A, 8'h0B, 16'h006E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
